led_matrix_scanner: RTL and testbench
=====================================

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: system cycles per sclk half-period (>=1).
REQ-002 SHALL have parameter ON_CYCLES, default 256: cycles each row is lit (>=1).
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame  input  256  16x16 pixel frame; bit r*16+c = row r, column c.
REQ-006 SHALL have port frame_valid  input  1  upstream holds high while frame is stable.
REQ-007 SHALL have port frame_ready  output  1  one-cycle capture strobe.
REQ-008 SHALL have port sdata  output  1  serial column data to the panel shift register.
REQ-009 SHALL have port sclk  output  1  panel shift clock; data sampled by panel on rising sclk.
REQ-010 SHALL have port latch  output  1  one-cycle pulse transferring shifted row to panel outputs.
REQ-011 SHALL have port oe_n  output  1  active-low panel output enable.
REQ-012 SHALL have port row_addr  output  4  row currently driven by the panel.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at end of each 16-row scan.

Function
REQ-014 SHALL sequence states LOAD -> (SHIFT -> LATCH -> DISPLAY) x16 rows -> LOAD, forever.
REQ-015 LOAD SHALL last 1 cycle with frame_ready=1; if frame_valid=1 that cycle, frame SHALL be copied into a 256-bit shadow buffer, else shadow SHALL be kept unchanged.
REQ-016 All shifted data SHALL come from the shadow buffer; frame changes outside LOAD SHALL have no effect on the current scan.
REQ-017 SHIFT SHALL output the 16 bits of row r column 15 first down to column 0, each bit for 2*CLK_DIV cycles: sclk=0 for the first CLK_DIV cycles, sclk=1 for the last CLK_DIV; sdata stable across the whole bit.
REQ-018 LATCH SHALL last 1 cycle with latch=1, sclk=0, and row_addr updated to r in that same cycle.
REQ-019 DISPLAY SHALL last ON_CYCLES cycles with oe_n=0; oe_n SHALL be 1 in LOAD, SHIFT and LATCH.
REQ-020 After DISPLAY of row 15, row counter SHALL wrap to 0, FSM SHALL enter LOAD, and frame_done SHALL be 1 in that LOAD cycle only.
REQ-021 Row period SHALL be exactly 32*CLK_DIV+1+ON_CYCLES cycles; frame period exactly 1+16*row period (5137 at defaults).
REQ-022 frame_ready and frame_done SHALL be 0 in all non-LOAD cycles; first LOAD after reset SHALL NOT assert frame_done.
REQ-023 Internal counters SHALL be sized from parameters ($clog2) and SHALL never overflow at any legal parameter value.

Reset
REQ-024 While reset=1: state=LOAD-pending, shadow=0, sdata=0, sclk=0, latch=0, oe_n=1, row_addr=0, frame_ready=0, frame_done=0, all counters 0.
REQ-025 First cycle after reset deassertion SHALL be LOAD (frame_ready=1).
REQ-026 Reset asserted mid-scan SHALL immediately (asynchronously) force oe_n=1 and all REQ-024 values; no partial row SHALL be latched.

Structure
REQ-027 A shared package led_pkg SHALL hold MATRIX_DIM=16, FRAME_BITS=256 and the scanner state enum.
REQ-028 A single sub-module led_row_shifter (16-bit parallel-load, MSB-first shift register with bit-timing counter) SHALL implement SHIFT; FSM and row/display counters stay in led_matrix_scanner.

Verification
REQ-029 Reset release, frame_valid=1, frame with only bit 0 set: row 0 shifts 15 zeros then sdata=1 on 16th bit; all other rows all zeros; frame_ready at cycle 0.
REQ-030 Defaults: measure latch pulses 321 cycles apart, frame_done pulses 5137 cycles apart, row_addr 0..15 then wrap to 0.
REQ-031 frame_valid=0 at a LOAD with shadow holding 0xA5A5 rows: next scan repeats identical sdata sequence; change frame mid-scan -> no effect until next LOAD with frame_valid=1.
REQ-032 CLK_DIV=1, ON_CYCLES=1: sclk toggles every cycle, row period 34, frame period 545, oe_n low exactly 1 cycle per row.
REQ-033 Assert reset during SHIFT of row 7: oe_n=1 and latch=0 same cycle without clock edge; after release, scan restarts at LOAD with row_addr=0.
REQ-034 Checker: oe_n=0 never coincides with sclk=1 or latch=1; sdata never changes while sclk=1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants, scanner state encoding and row extraction helper for the
// 16x16 LED matrix scanner.
package led_pkg;

  localparam int MATRIX_DIM = 16;
  localparam int FRAME_BITS = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } scan_state_e;

  // Bit r*16+c of the frame is row r, column c; the returned word keeps column 15 as its MSB.
  function automatic logic [MATRIX_DIM-1:0] row_word(input logic [FRAME_BITS-1:0] frm,
                                                     input logic [3:0] row);
    return frm[{row, 4'b0000} +: MATRIX_DIM];
  endfunction

endpackage

// File: rtl/led_row_shifter.sv
// MSB-first 16-bit serializer: every bit is held for 2*CLK_DIV cycles, with sclk
// low for the first half and high for the second.
module led_row_shifter
  import led_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [MATRIX_DIM-1:0] data_i,
  output logic                  sdata_o,
  output logic                  sclk_o,
  output logic                  done_o
);

  localparam int              PW       = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0]   PH_RISE  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]   PH_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [3:0]      BIT_LAST = 4'(MATRIX_DIM - 1);

  logic                  active_q, active_d;
  logic [MATRIX_DIM-1:0] shreg_q, shreg_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [3:0]            bit_q, bit_d;
  logic                  sclk_q, sclk_d;

  // Shift register, bit timing and sclk registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      shreg_q  <= '0;
      phase_q  <= '0;
      bit_q    <= 4'd0;
      sclk_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      shreg_q  <= shreg_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
    end
  end

  // Next bit/phase; sdata is the shift register MSB so it only moves at bit boundaries.
  always_comb begin
    active_d = active_q;
    shreg_d  = shreg_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    if (load_i) begin
      active_d = 1'b1;
      shreg_d  = data_i;
      phase_d  = '0;
      bit_d    = 4'd0;
      sclk_d   = 1'b0;
    end else if (active_q) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        sclk_d  = 1'b0;
        if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
          shreg_d  = '0;
          bit_d    = 4'd0;
        end else begin
          bit_d   = bit_q + 4'd1;
          shreg_d = {shreg_q[MATRIX_DIM-2:0], 1'b0};
        end
      end else begin
        phase_d = phase_q + PW'(1);
        if (phase_q == PH_RISE) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = sclk_q;
        end
      end
    end else begin
      sclk_d  = 1'b0;
      shreg_d = '0;
    end
  end

  assign sdata_o = shreg_q[MATRIX_DIM-1];
  assign sclk_o  = sclk_q;
  assign done_o  = active_q && (phase_q == PH_LAST) && (bit_q == BIT_LAST);

endmodule

// File: rtl/led_scanner_checker.sv
// Panel protocol properties: outputs never enabled while shifting or latching,
// and serial data held steady while sclk is high.
module led_scanner_checker (
  input logic clk,
  input logic reset,
  input logic oe_n,
  input logic sclk,
  input logic latch,
  input logic sdata
);

  a_oe_quiet: assert property (@(posedge clk) disable iff (reset)
    !oe_n |-> (!sclk && !latch))
    else $error("oe_n low while sclk or latch high");

  a_sdata_stable: assert property (@(posedge clk) disable iff (reset)
    (sclk && $past(sclk)) |-> (sdata == $past(sdata)))
    else $error("sdata moved while sclk high");

endmodule

// File: rtl/led_matrix_scanner.sv
// 16x16 LED matrix scan controller: captures a frame into a shadow buffer once per
// scan, then shifts, latches and displays each row in turn.
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int ON_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  sdata,
  output logic                  sclk,
  output logic                  latch,
  output logic                  oe_n,
  output logic [3:0]            row_addr,
  output logic                  frame_done
);

  localparam int            DW        = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam logic [DW-1:0] DISP_LAST = DW'(ON_CYCLES - 1);
  localparam logic [3:0]    ROW_LAST  = 4'(MATRIX_DIM - 1);

  scan_state_e           state_q, state_d;
  logic [3:0]            row_q, row_d;
  logic [DW-1:0]         disp_cnt_q, disp_cnt_d;
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic                  frame_ready_q, frame_ready_d;
  logic                  frame_done_q, frame_done_d;
  logic                  latch_q, latch_d;
  logic                  oe_n_q, oe_n_d;
  logic [3:0]            row_addr_q, row_addr_d;
  logic                  disp_last_s;
  logic                  shift_load_s;
  logic                  shift_done_s;
  logic [MATRIX_DIM-1:0] shift_data_s;

  assign disp_last_s = (disp_cnt_q == DISP_LAST);

  // State register; ST_IDLE is the reset-pending state ahead of the first LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (shift_done_s) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_LATCH:   state_d = ST_DISPLAY;
      ST_DISPLAY: begin
        if (!disp_last_s) begin
          state_d = ST_DISPLAY;
        end else if (row_q == ROW_LAST) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    row_d         = row_q;
    disp_cnt_d    = '0;
    shadow_d      = shadow_q;
    if (state_q == ST_DISPLAY && disp_last_s) begin
      row_d = row_q + 4'd1;
    end else begin
      row_d = row_q;
    end
    if (state_q == ST_DISPLAY && !disp_last_s) begin
      disp_cnt_d = disp_cnt_q + DW'(1);
    end else begin
      disp_cnt_d = '0;
    end
    if (state_q == ST_LOAD && frame_valid) begin
      shadow_d = frame;
    end else begin
      shadow_d = shadow_q;
    end
    shift_load_s  = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
    shift_data_s  = row_word(shadow_d, row_d);
    frame_ready_d = (state_d == ST_LOAD);
    frame_done_d  = (state_d == ST_LOAD) && (state_q == ST_DISPLAY);
    latch_d       = (state_d == ST_LATCH);
    oe_n_d        = (state_d != ST_DISPLAY);
    if (state_d == ST_LATCH) begin
      row_addr_d = row_q;
    end else begin
      row_addr_d = row_addr_q;
    end
  end

  // Counters, shadow buffer and registered panel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q         <= 4'd0;
      disp_cnt_q    <= '0;
      shadow_q      <= '0;
      frame_ready_q <= 1'b0;
      frame_done_q  <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      row_addr_q    <= 4'd0;
    end else begin
      row_q         <= row_d;
      disp_cnt_q    <= disp_cnt_d;
      shadow_q      <= shadow_d;
      frame_ready_q <= frame_ready_d;
      frame_done_q  <= frame_done_d;
      latch_q       <= latch_d;
      oe_n_q        <= oe_n_d;
      row_addr_q    <= row_addr_d;
    end
  end

  led_row_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load_i  (shift_load_s),
    .data_i  (shift_data_s),
    .sdata_o (sdata),
    .sclk_o  (sclk),
    .done_o  (shift_done_s)
  );

  assign frame_ready = frame_ready_q;
  assign frame_done  = frame_done_q;
  assign latch       = latch_q;
  assign oe_n        = oe_n_q;
  assign row_addr    = row_addr_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomized bench for led_matrix_scanner: default and minimal-parameter instances
// are compared every cycle against an arithmetic frame-timing model.
module tb_led_matrix_scanner;

  localparam int CD0 = 2;
  localparam int ON0 = 256;
  localparam int CD1 = 1;
  localparam int ON1 = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] frame = '0;
  logic         frame_valid = 1'b0;

  logic       fr0, sd0, sc0, la0, oe0, fd0;
  logic [3:0] ra0;
  logic       fr1, sd1, sc1, la1, oe1, fd1;
  logic [3:0] ra1;

  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;
  logic [255:0] model_shadow = '0;

  always #5 clk = ~clk;

  led_matrix_scanner #(.CLK_DIV(CD0), .ON_CYCLES(ON0)) dut0 (
    .clk(clk), .reset(reset), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(fr0), .sdata(sd0), .sclk(sc0), .latch(la0), .oe_n(oe0),
    .row_addr(ra0), .frame_done(fd0));

  led_matrix_scanner #(.CLK_DIV(CD1), .ON_CYCLES(ON1)) dut1 (
    .clk(clk), .reset(reset), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(fr1), .sdata(sd1), .sclk(sc1), .latch(la1), .oe_n(oe1),
    .row_addr(ra1), .frame_done(fd1));

  led_scanner_checker chk0 (.clk(clk), .reset(reset), .oe_n(oe0), .sclk(sc0), .latch(la0), .sdata(sd0));
  led_scanner_checker chk1 (.clk(clk), .reset(reset), .oe_n(oe1), .sclk(sc1), .latch(la1), .sdata(sd1));

  // {frame_ready, frame_done, sclk, latch, oe_n, sdata, row_addr}
  function automatic logic [9:0] obs(input int s);
    if (s == 1) return {fr1, fd1, sc1, la1, oe1, sd1, ra1};
    return {fr0, fd0, sc0, la0, oe0, sd0, ra0};
  endfunction

  function automatic int row_period(input int s);
    if (s == 1) return 32 * CD1 + 1 + ON1;
    return 32 * CD0 + 1 + ON0;
  endfunction

  function automatic int frame_period(input int s);
    return 1 + 16 * row_period(s);
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    model_shadow = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Checks ncyc cycles starting at a LOAD cycle; offered frame is presented during that LOAD.
  task automatic run_frame(input int s, input logic valid, input logic [255:0] nf,
                           input bit first, input int ncyc);
    int cd, rp, u, r, k, b, ph;
    logic [4:0] e_ctl;
    logic       e_sd;
    logic [3:0] e_ra;
    logic       care_sd;
    logic [9:0] o;
    cd = (s == 1) ? CD1 : CD0;
    rp = row_period(s);
    for (int t = 0; t < ncyc; t++) begin
      care_sd = 1'b0;
      e_sd    = 1'b0;
      if (t == 0) begin
        e_ctl = {1'b1, !first, 1'b0, 1'b0, 1'b1};
        e_ra  = first ? 4'd0 : 4'd15;
      end else begin
        u = t - 1;
        r = u / rp;
        k = u % rp;
        if (k < 32 * cd) begin
          b  = k / (2 * cd);
          ph = k % (2 * cd);
          e_ctl   = {1'b0, 1'b0, (ph >= cd) ? 1'b1 : 1'b0, 1'b0, 1'b1};
          care_sd = 1'b1;
          e_sd    = model_shadow[r * 16 + 15 - b];
          e_ra    = (r == 0) ? (first ? 4'd0 : 4'd15) : 4'(r - 1);
        end else if (k == 32 * cd) begin
          e_ctl = 5'b00011;
          e_ra  = 4'(r);
        end else begin
          e_ctl = 5'b00000;
          e_ra  = 4'(r);
        end
      end
      o = obs(s);
      vectors++;
      if (o[9:5] !== e_ctl || o[3:0] !== e_ra || (care_sd && o[4] !== e_sd)) begin
        miscompares++;
        if (fail_prints < 20)
          $display("FAIL scan dut%0d t=%0d: got ctl=%b sdata=%b row=%0d, expected ctl=%b sdata=%b(care=%0d) row=%0d",
                   s, t, o[9:5], o[4], o[3:0], e_ctl, e_sd, care_sd, e_ra);
        fail_prints++;
      end
      if (t == 0) begin
        frame = nf;
        frame_valid = valid;
        if (valid) model_shadow = nf;
      end else if (t == ncyc / 2) begin
        frame = rand_frame();
        frame_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [9:0] o;
    reset = 1'b1;
    frame = rand_frame();
    frame_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      o = obs(s);
      vectors++;
      if (o !== 10'b00001_0_0000) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %b expected %b", s, o, 10'b00001_0_0000);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    o = obs(0);
    vectors++;
    if (o[9:8] !== 2'b10) begin
      miscompares++;
      $display("FAIL first_load: got ready/done=%b expected 10", o[9:8]);
    end
  endtask

  task automatic test_single_pixel();
    do_reset();
    run_frame(0, 1'b1, 256'd1, 1'b1, frame_period(0));
  endtask

  task automatic test_hold();
    run_frame(0, 1'b1, {16{16'hA5A5}}, 1'b0, frame_period(0));
    run_frame(0, 1'b0, rand_frame(), 1'b0, frame_period(0));
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 2; i++)
      run_frame(0, 1'($urandom_range(0, 1)), rand_frame(), 1'b0, frame_period(0));
  endtask

  // Edge-to-edge spacing of frame_done (bit 8) and latch (bit 6).
  task automatic test_periods(input int s);
    int cnt;
    int want [2];
    int bitpos [2];
    want[0] = frame_period(s);  bitpos[0] = 8;
    want[1] = row_period(s);    bitpos[1] = 6;
    for (int m = 0; m < 2; m++) begin
      cnt = 0;
      while (obs(s)[bitpos[m]] !== 1'b1 && cnt <= want[m] + 2) begin
        @(posedge clk); #1; cnt++;
      end
      cnt = 0;
      do begin
        @(posedge clk); #1; cnt++;
      end while (obs(s)[bitpos[m]] !== 1'b1 && cnt <= want[m] + 2);
      vectors++;
      if (cnt != want[m]) begin
        miscompares++;
        $display("FAIL period dut%0d sig=%0d: got %0d cycles expected %0d", s, bitpos[m], cnt, want[m]);
      end
    end
  endtask

  task automatic test_reset_midscan();
    logic [9:0] o;
    do_reset();
    run_frame(0, 1'b1, rand_frame(), 1'b1, 1 + 7 * row_period(0) + 10);
    #2;
    reset = 1'b1;
    #1;
    o = obs(0);
    vectors++;
    if (o !== 10'b00001_0_0000) begin
      miscompares++;
      $display("FAIL async_reset: got %b expected %b", o, 10'b00001_0_0000);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_shadow = '0;
    @(posedge clk);
    #1;
    run_frame(0, 1'b0, rand_frame(), 1'b1, frame_period(0));
  endtask

  task automatic test_small_params();
    do_reset();
    run_frame(1, 1'b1, rand_frame(), 1'b1, frame_period(1));
    run_frame(1, 1'b0, rand_frame(), 1'b0, frame_period(1));
    run_frame(1, 1'b1, rand_frame(), 1'b0, frame_period(1));
    test_periods(1);
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_hold();
    test_random_frames();
    test_periods(0);
    test_reset_midscan();
    test_small_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
